sensor_sched: RTL and testbench
===============================

// Module: sensor_sched
// PURPOSE
//  Time-multiplexes one shared data_processor/filter pipeline between N_CH sensor channels.
//  Round-robin picks one pending sample, drives it onto the processor input and holds it
//  stable for the filter latency. It then captures processed_data and returns it tagged
//  with its channel id over a valid/ready response port. Sits between sensor front-ends
//  and the single data_processor instance.
// PARAMETERS
//  N_CH        4   number of requesting sensor channels (>=2)
//  DATA_W      8   sample width; must match data_processor
//  FILTER_LAT  2   register stages clk->processed_data in data_processor (>=1)
// PORTS
//  clk             in   1             system clock, all logic rising-edge
//  reset_n         in   1             asynchronous active-low reset
//  req_valid       in   N_CH          per-channel sample pending
//  req_data        in   N_CH*DATA_W   per-channel sample, ch i at [i*DATA_W +: DATA_W]
//  req_ready       out  N_CH          one-hot accept strobe, only in IDLE
//  sensor_data     out  DATA_W        to data_processor.sensor_data
//  processed_data  in   DATA_W        from data_processor.processed_data
//  rsp_valid       out  1             result available
//  rsp_ready       in   1             consumer accepts result
//  rsp_ch          out  $clog2(N_CH)  channel id of result
//  rsp_data        out  DATA_W        processed sample
//  busy            out  1             state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, sensor_data=0, rsp_valid=0,
//    rsp_ch=0, rsp_data=0, req_ready=0, busy=0, rr pointer=N_CH-1 (ch0 wins first).
//  - FSM IDLE -> WAIT -> RESP -> IDLE; one sample in flight at a time.
//  - IDLE: if any req_valid, grant = first set bit searching from ptr+1 modulo N_CH.
//    req_ready[grant]=1 combinationally that cycle and the handshake completes.
//    At the edge: sensor_data<=req_data[grant], rsp_ch<=grant, ptr<=grant,
//    cnt<=FILTER_LAT, go WAIT. With no req_valid, stay in IDLE and hold all registers.
//  - WAIT: sensor_data held constant; cnt decrements each edge. At the edge where
//    cnt==0: rsp_data<=processed_data, rsp_valid<=1, go RESP.
//  - Latency: rsp_valid rises FILTER_LAT+1 edges after the accepting edge.
//  - RESP: rsp_valid, rsp_ch, rsp_data held stable until rsp_valid&rsp_ready. At that
//    edge rsp_valid<=0, go IDLE. rsp_ready high in the first RESP cycle completes
//    immediately.
//  - Throughput: one sample per FILTER_LAT+3 cycles minimum; IDLE lasts >=1 cycle.
//  - req_ready is 0 in WAIT/RESP; requests are not queued internally.
//    Requester contract: valid/data held until ready.
//  - req_valid dropped before grant: the channel is simply not granted; no error.
//  - Reset mid-operation: in-flight sample and pending response discarded, no rsp
//    handshake; after release ch0 has priority again.
//  - rr pointer advances only on accept, so a lone requester is granted back-to-back.
// STRUCTURE
//  - sensor_pkg: sched_state_e {IDLE,WAIT,RESP}; DATA_W default constant shared with
//    data_processor/filter.
//  - Sub-module rr_arbiter #(N): inputs req, ptr, en; outputs one-hot gnt and binary
//    gnt_idx; purely combinational.
//  - cnt width $clog2(FILTER_LAT+1).
// TESTING
//  Filter stub = FILTER_LAT-stage identity+1 pipeline (out = in+1, delayed).
//  1. Reset, no requests for 10 cycles -> every output 0, busy=0, req_ready=0.
//  2. ch2 valid data 0x5A, rsp_ready=1 -> req_ready=4'b0100 one cycle; rsp_valid
//     FILTER_LAT+1 edges later with rsp_ch=2, rsp_data=0x5B; back to IDLE.
//  3. All 4 channels held valid (data 0x10,0x20,0x30,0x40) -> grant order
//     0,1,2,3,0; rsp_data 0x11,0x21,0x31,0x41,0x11.
//  4. rsp_ready low 5 cycles in RESP -> rsp_ch/rsp_data stable, req_ready=0 throughout,
//     busy=1; release -> completes one edge later.
//  5. reset_n pulsed low during WAIT -> rsp_valid never rises for that sample;
//     after release, ch0 and ch3 valid -> ch0 granted.
//  6. Only ch1 valid continuously -> granted on every IDLE; period exactly
//     FILTER_LAT+3 cycles with rsp_ready=1.

Source files
------------

// File: rtl/sensor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_pkg                                                                 |
// | Shared types and constants for the sensor scheduler / data_processor.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sensor_pkg;

  localparam int unsigned c_data_w = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sensor_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_sched_if                                                            |
// | Request (per-channel) and response handshake bundle of sensor_sched.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sensor_sched_if
  import sensor_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = c_data_w
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        req_valid;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CH_W-1:0]        rsp_ch;
  logic [DATA_W-1:0]      rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_ch, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_ch, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin pick: first request searching from ptr+1.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  int w_k;

  // Walk from lowest priority (ptr itself) to highest (ptr+1); the last hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_k     = 0;
    if (en) begin
      for (int i = N; i >= 1; i--) begin
        w_k = (int'(ptr) + i) % N;
        if (req[w_k]) begin
          gnt      = '0;
          gnt[w_k] = 1'b1;
          gnt_idx  = IDX_W'(w_k);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_sched                                                               |
// | Round-robin time-multiplexing of N_CH sensor channels onto one filter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sensor_sched
  import sensor_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = c_data_w,
  parameter int FILTER_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  sensor_sched_if.slave     bus,
  output logic [DATA_W-1:0] sensor_data,
  input  logic [DATA_W-1:0] processed_data,
  output logic              busy
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(FILTER_LAT + 1);

  sched_state_e      r_state;
  logic [CH_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sensor_data;
  logic              r_rsp_valid;
  logic [CH_W-1:0]   r_rsp_ch;
  logic [DATA_W-1:0] r_rsp_data;

  logic [N_CH-1:0]   w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_arb_en;
  logic [DATA_W-1:0] w_sel_data;

  // Gating with reset_n keeps req_ready low while reset is asserted.
  assign w_arb_en   = reset_n && (r_state == IDLE);
  assign w_sel_data = bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

  rr_arbiter #(.N(N_CH)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= CH_W'(N_CH - 1);
      r_cnt         <= '0;
      r_sensor_data <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_ch      <= '0;
      r_rsp_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_sensor_data <= w_sel_data;
            r_rsp_ch      <= w_gnt_idx;
            r_ptr         <= w_gnt_idx;
            r_cnt         <= CNT_W'(FILTER_LAT);
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= processed_data;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_ch    = r_rsp_ch;
  assign bus.rsp_data  = r_rsp_data;
  assign sensor_data   = r_sensor_data;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sensor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sensor_sched                                                            |
// | Random requests/backpressure checked against a transaction-level model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sensor_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] sensor_data;
  logic [DW-1:0] processed_data;
  logic          busy;
  logic [DW-1:0] pipe [L];

  int total = 0;
  int bad   = 0;

  // Reference model state: one sample in flight, timed by edge numbers.
  int            edges = 0;
  bit            in_flight = 0;
  int            acc_edge = 0;
  int            exp_ch = 0;
  logic [DW-1:0] exp_sens = '0;
  logic [DW-1:0] exp_d = '0;
  int            last = N - 1;
  int            last_acc = -1;
  bit            chk_period = 0;

  sensor_sched_if #(.N_CH(N), .DATA_W(DW)) bus ();

  sensor_sched #(.N_CH(N), .DATA_W(DW), .FILTER_LAT(L)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .sensor_data    (sensor_data),
    .processed_data (processed_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Filter stub: L register stages computing in+1.
  always @(posedge clk) begin
    pipe[0] <= sensor_data + 1'b1;
    for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
  end
  assign processed_data = pipe[L-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Called at a negedge: update stimulus, check outputs, advance one edge.
  task automatic run_cycle(input int p_req, input int p_drop, input int p_rdy,
                           input logic [N-1:0] chmask, input bit fixed);
    int            g;
    bit            hs;
    bit            exp_rv;
    logic [DW-1:0] gd;
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] && chmask[i] && ($urandom_range(0, 99) < p_req)) begin
        bus.req_valid[i] = 1'b1;
        bus.req_data[i*DW +: DW] = fixed ? DW'((i + 1) << 4) : DW'($urandom);
      end else if (bus.req_valid[i] && ($urandom_range(0, 99) < p_drop)) begin
        bus.req_valid[i] = 1'b0;
      end
    end
    bus.rsp_ready = ($urandom_range(0, 99) < p_rdy);
    #1;
    exp_rv = in_flight && ((edges - acc_edge) >= L + 1);
    g = in_flight ? -1 : pick(bus.req_valid);
    check_eq("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check_eq("busy", 32'(busy), 32'(in_flight));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (in_flight) check_eq("sensor_data", 32'(sensor_data), 32'(exp_sens));
    if (exp_rv) begin
      check_eq("rsp_ch", 32'(bus.rsp_ch), 32'(exp_ch));
      check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    end
    hs = exp_rv && bus.rsp_ready;
    gd = (g >= 0) ? bus.req_data[g*DW +: DW] : '0;
    @(posedge clk);
    edges++;
    if (g >= 0) begin
      if (chk_period && last_acc >= 0) check_eq("period", 32'(edges - last_acc), 32'(L + 3));
      last_acc  = edges;
      in_flight = 1'b1;
      acc_edge  = edges;
      exp_ch    = g;
      exp_sens  = gd;
      exp_d     = gd + 1'b1;
      last      = g;
    end
    if (hs) in_flight = 1'b0;
    @(negedge clk);
    if (g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  // Called at a negedge: pulse reset for n edges, checking the reset values.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_sensor_data", 32'(sensor_data), 32'd0);
    check_eq("rst_rsp_ch", 32'(bus.rsp_ch), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    in_flight = 1'b0;
    last      = N - 1;
    last_acc  = -1;
    repeat (n) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Idle after reset: nothing moves for 10 cycles.
    repeat (10) run_cycle(0, 0, 100, '0, 0);
    check_eq("idle_sensor_data", 32'(sensor_data), 32'd0);
    check_eq("idle_rsp_data", 32'(bus.rsp_data), 32'd0);

    // Single request on ch2.
    bus.req_valid[2] = 1'b1;
    bus.req_data[2*DW +: DW] = 8'h5A;
    repeat (8) run_cycle(0, 0, 100, '0, 0);

    // All channels held valid with fixed data: strict rotation.
    repeat (30) run_cycle(100, 0, 100, 4'hF, 1);

    // Response backpressure.
    repeat (12) run_cycle(100, 0, 0, 4'hF, 1);
    repeat (10) run_cycle(100, 0, 100, 4'hF, 1);

    // Reset while a sample is in WAIT, then ch0 and ch3 compete.
    bus.req_valid = '0;
    repeat (8) run_cycle(0, 0, 100, '0, 0);
    bus.req_valid[1] = 1'b1;
    bus.req_data[1*DW +: DW] = 8'hC3;
    guard = 0;
    while (!(in_flight && (edges - acc_edge) == 1) && guard < 20) begin
      run_cycle(0, 0, 100, '0, 0);
      guard++;
    end
    check_eq("reach_wait", 32'(guard < 20), 32'd1);
    do_reset(2);
    bus.req_valid = '0;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    bus.req_data[0*DW +: DW] = 8'h01;
    bus.req_data[3*DW +: DW] = 8'h33;
    #1;
    check_eq("post_rst_grant", 32'(bus.req_ready), 32'b0001);
    repeat (12) run_cycle(0, 0, 100, '0, 0);

    // Lone requester ch1: back-to-back grants at the minimum period.
    bus.req_valid = '0;
    repeat (6) run_cycle(0, 0, 100, '0, 0);
    chk_period = 1'b1;
    last_acc   = -1;
    repeat (30) run_cycle(100, 0, 100, 4'b0010, 0);
    chk_period = 1'b0;

    // Random traffic with drops, backpressure and occasional resets.
    for (int r = 0; r < 2000; r++) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
      else run_cycle(30, 3, 60, '1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
